// File: rtl/stack_pkg.sv
// Shared definitions for lifo_stack: stack operation encoding and the
// request decode rule that picks one operation per clock edge.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // Push+Pop on an empty stack degrades to a plain push; rejected requests become idle.
    function automatic op_e decode_op(input logic push, input logic pop,
                                      input logic full, input logic empty);
        op_e op;
        op = OP_IDLE;
        case ({push, pop})
            2'b10: begin
                if (full) op = OP_IDLE;
                else      op = OP_PUSH;
            end
            2'b01: begin
                if (empty) op = OP_IDLE;
                else       op = OP_POP;
            end
            2'b11: begin
                if (empty) op = OP_PUSH;
                else       op = OP_REPL;
            end
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// WIDTH x DEPTH storage array for lifo_stack: one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module stack_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    w_widx;
    logic [IW-1:0]    w_ridx;

    assign w_widx = i_waddr[IW-1:0];
    assign w_ridx = i_raddr[IW-1:0];

    // Storage write; out-of-range addresses are dropped.
    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr < AW'(DEPTH))) begin
            r_mem[w_widx] <= i_wdata;
        end
    end

    // Asynchronous read; the all-ones address seen on an empty stack returns zero.
    always_comb begin
        o_rdata = '0;
        if (i_raddr < AW'(DEPTH)) begin
            o_rdata = r_mem[w_ridx];
        end else begin
            o_rdata = '0;
        end
    end

endmodule

// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO with replace-top, top peek, occupancy count and
// pop-valid strobe. Define STACK_ERR_EN to add sticky Overflow/Underflow flags.
module lifo_stack
    import stack_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Push,
    input  logic             Pop,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Valid_Out,
    output logic [WIDTH-1:0] Top,
    output logic [CW-1:0]    Count,
    output logic             Full,
`ifdef STACK_ERR_EN
    output logic             Overflow,
    output logic             Underflow,
`endif
    output logic             Empty
);

    op_e              w_op;
    logic [CW-1:0]    w_top_addr;
    logic [CW-1:0]    w_waddr;
    logic             w_we;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_top;

    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;

    assign w_op       = decode_op(Push, Pop, r_full, r_empty);
    assign w_top_addr = r_count - CW'(1);

    // Write-port steering and next occupancy for the decoded operation.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_count;
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: begin
                w_we        = 1'b1;
                w_waddr     = r_count;
                w_count_nxt = r_count + CW'(1);
            end
            OP_POP: begin
                w_we        = 1'b0;
                w_waddr     = r_count;
                w_count_nxt = r_count - CW'(1);
            end
            OP_REPL: begin
                w_we        = 1'b1;
                w_waddr     = w_top_addr;
                w_count_nxt = r_count;
            end
            default: begin
                w_we        = 1'b0;
                w_waddr     = r_count;
                w_count_nxt = r_count;
            end
        endcase
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (CW)
    ) u_regfile (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (Data_In),
        .i_raddr (w_top_addr),
        .o_rdata (w_top)
    );

    // Occupancy and flags; Full/Empty derive from the next count so they track Count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == CW'(0));
        end
    end

    // Popped word and its one-cycle strobe; Data_Out holds between accepted pops.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else if ((w_op == OP_POP) || (w_op == OP_REPL)) begin
            r_data_out  <= w_top;
            r_valid_out <= 1'b1;
        end else begin
            r_valid_out <= 1'b0;
        end
    end

`ifdef STACK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (Push && !Pop && r_full) r_overflow <= 1'b1;
            if (Pop && r_empty)         r_underflow <= 1'b1;
        end
    end

    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;
`endif

    assign Data_Out  = r_data_out;
    assign Valid_Out = r_valid_out;
    assign Top       = w_top;
    assign Count     = r_count;
    assign Full      = r_full;
    assign Empty     = r_empty;

endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a 4x8 and a 16x32 instance, driven one at a
// time against a queue-based stack model. Honours STACK_ERR_EN if defined.
module tb_lifo_stack;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst = 1'b1;
    logic [3:0]  a_din = '0;
    logic        a_push = 1'b0, a_pop = 1'b0;
    logic [3:0]  a_dout, a_top;
    logic        a_valid, a_full, a_empty;
    logic [3:0]  a_count;
    logic [15:0] b_din = '0;
    logic        b_push = 1'b0, b_pop = 1'b0;
    logic [15:0] b_dout, b_top;
    logic        b_valid, b_full, b_empty;
    logic [5:0]  b_count;
`ifdef STACK_ERR_EN
    logic        a_ovf, a_unf, b_ovf, b_unf;
`endif

    lifo_stack #(.WIDTH(4), .DEPTH(8)) u_a (
        .Clk(Clk), .Rst(Rst), .Data_In(a_din), .Push(a_push), .Pop(a_pop),
        .Data_Out(a_dout), .Valid_Out(a_valid), .Top(a_top), .Count(a_count),
        .Full(a_full),
`ifdef STACK_ERR_EN
        .Overflow(a_ovf), .Underflow(a_unf),
`endif
        .Empty(a_empty)
    );

    lifo_stack #(.WIDTH(16), .DEPTH(32)) u_b (
        .Clk(Clk), .Rst(Rst), .Data_In(b_din), .Push(b_push), .Pop(b_pop),
        .Data_Out(b_dout), .Valid_Out(b_valid), .Top(b_top), .Count(b_count),
        .Full(b_full),
`ifdef STACK_ERR_EN
        .Overflow(b_ovf), .Underflow(b_unf),
`endif
        .Empty(b_empty)
    );

    int          sel   = 0;
    int          depth = 8;
    logic [15:0] mdl[$];
    logic [15:0] expq[$];
    logic [15:0] exp_dout = '0;
    bit          ovf = 1'b0, unf = 1'b0;
    int          n_cmp = 0, n_err = 0;

    logic [15:0] m_dout, m_top;
    logic [31:0] m_count;
    logic        m_valid, m_full, m_empty, m_ovf, m_unf;

    always_comb begin
        m_dout  = sel ? b_dout  : {12'h000, a_dout};
        m_top   = sel ? b_top   : {12'h000, a_top};
        m_count = sel ? 32'(b_count) : 32'(a_count);
        m_valid = sel ? b_valid : a_valid;
        m_full  = sel ? b_full  : a_full;
        m_empty = sel ? b_empty : a_empty;
`ifdef STACK_ERR_EN
        m_ovf   = sel ? b_ovf : a_ovf;
        m_unf   = sel ? b_unf : a_unf;
`else
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (inst %0d, t=%0t): got %0h, expected %0h", nm, sel, $time, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next scoreboard entry, and vice versa.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (m_valid) begin
                if (expq.size() == 0) chk("valid_spurious", 32'(m_valid), 32'd0);
                else                  chk("pop_data", 32'(m_dout), 32'(expq.pop_front()));
            end else if (expq.size() != 0) begin
                chk("valid_missing", 32'(m_valid), 32'd1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic check_state();
        chk("count", m_count, 32'(mdl.size()));
        chk("empty", 32'(m_empty), 32'(mdl.size() == 0));
        chk("full",  32'(m_full),  32'(mdl.size() == depth));
        chk("dout_hold", 32'(m_dout), 32'(exp_dout));
        if (mdl.size() != 0) chk("top", 32'(m_top), 32'(mdl[mdl.size()-1]));
`ifdef STACK_ERR_EN
        chk("overflow",  32'(m_ovf), 32'(ovf));
        chk("underflow", 32'(m_unf), 32'(unf));
`endif
    endtask

    task automatic drive(input bit push, input bit pop, input logic [15:0] d);
        a_push = 1'b0; a_pop = 1'b0; b_push = 1'b0; b_pop = 1'b0;
        if (sel == 0) begin a_push = push; a_pop = pop; a_din = d[3:0]; end
        else          begin b_push = push; b_pop = pop; b_din = d; end
    endtask

    task automatic step(input bit push, input bit pop, input logic [15:0] d);
        logic [15:0] dm;
        dm = (sel != 0) ? d : (d & 16'h000F);
        drive(push, pop, d);
        @(posedge Clk);
        if (push && pop) begin
            if (mdl.size() == 0) begin
                mdl.push_back(dm);
                unf = 1'b1;
            end else begin
                exp_dout = mdl[mdl.size()-1];
                expq.push_back(exp_dout);
                mdl[mdl.size()-1] = dm;
            end
        end else if (push) begin
            if (mdl.size() < depth) mdl.push_back(dm);
            else                    ovf = 1'b1;
        end else if (pop) begin
            if (mdl.size() > 0) begin
                exp_dout = mdl.pop_back();
                expq.push_back(exp_dout);
            end else begin
                unf = 1'b1;
            end
        end
        @(negedge Clk);
        check_state();
    endtask

    task automatic do_reset(input bit push_too);
        Rst = 1'b1;
        drive(push_too, 1'b0, 16'h0009);
        @(posedge Clk);
        mdl.delete();
        expq.delete();
        exp_dout = '0;
        ovf = 1'b0;
        unf = 1'b0;
        @(negedge Clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        check_state();
        Rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
    endtask

    task automatic random_ops(input int n);
        int pp;
        pp = 50;
        for (int i = 0; i < n; i++) begin
            if (i % 40 == 0) pp = $urandom_range(15, 85);
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1);
            else step(($urandom % 100) < pp, ($urandom % 100) < (100 - pp), 16'($urandom));
        end
    endtask

    initial begin
        // 4 x 8 instance: directed scenarios followed by random traffic.
        sel = 0; depth = 8;
        @(negedge Clk);
        do_reset(1'b0);
        step(1, 0, 16'h1); step(1, 0, 16'h2); step(1, 0, 16'h3);
        step(0, 1, 16'h0); step(0, 1, 16'h0); step(0, 1, 16'h0);
        step(0, 1, 16'h0);
        step(1, 0, 16'h5);
        step(1, 1, 16'hA);
        for (int i = 0; i < 8; i++) step(1, 0, 16'(i + 2));
        step(1, 0, 16'hF);
        step(1, 1, 16'hC);
        step(1, 1, 16'h6);
        do_reset(1'b0);
        step(1, 1, 16'h7);
        for (int i = 0; i < 4; i++) step(1, 0, 16'(i + 8));
        do_reset(1'b1);
        step(0, 1, 16'h0);
        random_ops(600);

        // 16 x 32 instance: fill to Full, overflow, replace, reset with push, random.
        sel = 1; depth = 32;
        do_reset(1'b0);
        for (int i = 0; i < 33; i++) step(1, 0, 16'($urandom));
        step(1, 1, 16'hBEEF);
        step(0, 1, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'($urandom));
        do_reset(1'b1);
        random_ops(500);

        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
